// File: rtl/lcd_refresh_ctrl_if.sv
// lcd_refresh_ctrl_if: formatter handshake, LCD pins and status of the refresh controller
interface lcd_refresh_ctrl_if;
  logic enable;
  logic refresh_req;
  logic [7:0] char_in;
  logic [4:0] index;
  logic lcd_e;
  logic lcd_rs;
  logic lcd_rw;
  logic [7:0] lcd_data;
  logic init_done;
  logic busy;
  logic frame_done;
  modport master(input enable, refresh_req, char_in,
                 output index, lcd_e, lcd_rs, lcd_rw, lcd_data, init_done, busy, frame_done);
  modport slave(output enable, refresh_req, char_in,
                input index, lcd_e, lcd_rs, lcd_rw, lcd_data, init_done, busy, frame_done);
endinterface

// File: rtl/lcd_refresh_ctrl.sv
// lcd_refresh_ctrl: HD44780 init then continuous 32-char refresh from the display formatter
module lcd_refresh_ctrl #(
  parameter int T_PWR_CYC   = 750000,
  parameter int T_SETUP_CYC = 4,
  parameter int T_EN_CYC    = 25,
  parameter int T_CMD_CYC   = 2500,
  parameter int T_CLR_CYC   = 100000,
  parameter int T_FRAME_CYC = 2500000,
  parameter int FETCH_CYC   = 2
) (
  input logic clk,
  input logic rst,
  lcd_refresh_ctrl_if.master bus
);
  function automatic int imax(input int a, input int b);
    return a > b ? a : b;
  endfunction
  localparam int WR_CLR = T_SETUP_CYC + T_EN_CYC + T_CLR_CYC;
  localparam int WR_CMD = T_SETUP_CYC + T_EN_CYC + T_CMD_CYC;
  localparam int CW = $clog2(imax(imax(T_PWR_CYC, T_FRAME_CYC), imax(WR_CLR, WR_CMD)) + 1);
  localparam logic [CW-1:0] PWR_END   = CW'(T_PWR_CYC - 1);
  localparam logic [CW-1:0] E_ON      = CW'(T_SETUP_CYC);
  localparam logic [CW-1:0] E_OFF     = CW'(T_SETUP_CYC + T_EN_CYC);
  localparam logic [CW-1:0] CMD_END   = CW'(WR_CMD - 1);
  localparam logic [CW-1:0] CLR_END   = CW'(WR_CLR - 1);
  localparam logic [CW-1:0] GAP_END   = CW'(T_FRAME_CYC);
  localparam logic [CW-1:0] FETCH_END = CW'(FETCH_CYC - 1);
  typedef enum logic [2:0] {PWR_WAIT, INIT, ADDR, FETCH, WR, GAP} state_t;
  state_t state, state_d, ret, ret_d;
  logic [CW-1:0] cnt, cnt_d, wr_end;
  logic [1:0] step, step_d;
  logic [4:0] idx, idx_d;
  logic [7:0] data, data_d, cmd;
  logic e, e_d, rs, rs_d, done, done_d, fd, fd_d, pend, pend_d, gap_exp;
  assign cmd = step == 2'd0 ? 8'h38 : step == 2'd1 ? 8'h0C : step == 2'd2 ? 8'h06 : 8'h01;
  assign wr_end = (!rs && data == 8'h01) ? CLR_END : CMD_END;
  assign gap_exp = cnt == GAP_END;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= PWR_WAIT;
      ret   <= PWR_WAIT;
      cnt   <= '0;
      step  <= '0;
      idx   <= '0;
      data  <= '0;
      e     <= 1'b0;
      rs    <= 1'b0;
      done  <= 1'b0;
      fd    <= 1'b0;
      pend  <= 1'b0;
    end else begin
      state <= state_d;
      ret   <= ret_d;
      cnt   <= cnt_d;
      step  <= step_d;
      idx   <= idx_d;
      data  <= data_d;
      e     <= e_d;
      rs    <= rs_d;
      done  <= done_d;
      fd    <= fd_d;
      pend  <= pend_d;
    end
  end
  always_comb begin
    state_d = state;
    ret_d   = ret;
    cnt_d   = cnt + 1'b1;
    step_d  = step;
    idx_d   = idx;
    data_d  = data;
    rs_d    = rs;
    done_d  = done;
    fd_d    = 1'b0;
    pend_d  = pend | (bus.refresh_req & done);
    case (state)
      PWR_WAIT, INIT: if (state == INIT || cnt == PWR_END) begin
        state_d = WR;
        ret_d   = INIT;
        rs_d    = 1'b0;
        data_d  = cmd;
        cnt_d   = '0;
      end
      ADDR: begin
        state_d = WR;
        ret_d   = ADDR;
        rs_d    = 1'b0;
        data_d  = idx[4] ? 8'hC0 : 8'h80;
        cnt_d   = '0;
      end
      FETCH: if (cnt == FETCH_END) begin
        state_d = WR;
        ret_d   = FETCH;
        rs_d    = 1'b1;
        data_d  = bus.char_in;
        cnt_d   = '0;
      end
      WR: if (cnt == wr_end) begin
        cnt_d = '0;
        if (ret == INIT) begin
          step_d  = step + 2'd1;
          state_d = step == 2'd3 ? GAP : INIT;
          done_d  = step == 2'd3;
          cnt_d   = step == 2'd3 ? GAP_END : '0;
        end else if (ret == ADDR) begin
          state_d = FETCH;
        end else begin
          idx_d   = idx + 5'd1;
          fd_d    = idx == 5'd31;
          state_d = idx == 5'd31 ? GAP : idx == 5'd15 ? ADDR : FETCH;
        end
      end
      GAP: begin
        cnt_d = gap_exp ? cnt : cnt + 1'b1;
        // pending requests bypass the inter-frame gap
        if ((gap_exp || pend) && bus.enable) begin
          state_d = ADDR;
          idx_d   = '0;
          cnt_d   = '0;
          pend_d  = 1'b0;
        end
      end
      default: state_d = PWR_WAIT;
    endcase
    e_d = state_d == WR && cnt_d >= E_ON && cnt_d < E_OFF;
  end
  assign bus.index      = idx;
  assign bus.lcd_e      = e;
  assign bus.lcd_rs     = rs;
  assign bus.lcd_rw     = 1'b0;
  assign bus.lcd_data   = data;
  assign bus.init_done  = done;
  assign bus.busy       = state != GAP;
  assign bus.frame_done = fd;
endmodule

// File: tb/tb_lcd_refresh_ctrl.sv
// tb_lcd_refresh_ctrl: scoreboard bench, expected LCD writes queued by stimulus, checked on each E rise
module tb_lcd_refresh_ctrl;
  localparam int T_PWR = 20, T_SETUP = 2, T_EN = 3, T_CMD = 5, T_CLR = 12, T_FRAME = 50;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  lcd_refresh_ctrl_if bus();
  lcd_refresh_ctrl #(
    .T_PWR_CYC(T_PWR), .T_SETUP_CYC(T_SETUP), .T_EN_CYC(T_EN), .T_CMD_CYC(T_CMD),
    .T_CLR_CYC(T_CLR), .T_FRAME_CYC(T_FRAME), .FETCH_CYC(2)
  ) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0, errors = 0, cyc = 0, fall_cyc = 0, frames = 0, e_rises = 0, hi = 0, last_hold = 0;
  bit seen_fall = 0;
  logic pe = 1'b0;
  logic [8:0] exp_q[$];
  logic [8:0] h1, h2, rise_val, cur;
  always @(posedge clk) cyc++;
  always @(posedge clk) bus.char_in <= 8'h40 + {3'b000, bus.index};
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic push_init();
    exp_q.push_back(9'h038);
    exp_q.push_back(9'h00C);
    exp_q.push_back(9'h006);
    exp_q.push_back(9'h001);
  endtask
  task automatic push_frame();
    exp_q.push_back(9'h080);
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, 8'(8'h40 + i)});
    exp_q.push_back(9'h0C0);
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, 8'(8'h50 + i)});
  endtask
  task automatic wait_idx(input logic [4:0] v, input bit need_e, input string name);
    int n = 0;
    while (!(bus.index == v && (!need_e || bus.lcd_e)) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(bus.index == v), 1);
  endtask
  task automatic wait_fd(input string name);
    int n = 0;
    while (!bus.frame_done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(bus.frame_done), 1);
  endtask
  task automatic count_to_e(output int n);
    n = 0;
    while (!bus.lcd_e && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask
  // scoreboard monitor plus E/setup/hold timing on every write
  always @(negedge clk) begin
    cur = {bus.lcd_rs, bus.lcd_data};
    if (rst) begin
      pe = 1'b0;
      seen_fall = 0;
      h1 = cur;
      h2 = cur;
    end else begin
      if (bus.frame_done) frames++;
      if (bus.lcd_e && !pe) begin
        e_rises++;
        hi = 1;
        rise_val = cur;
        check("setup_stable", int'(h1 == cur && h2 == cur), 1);
        check("lcd_rw", int'(bus.lcd_rw), 0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got %0h expected none", cur);
        end else check("write", int'(cur), int'(exp_q.pop_front()));
      end else if (bus.lcd_e) hi++;
      else if (pe) begin
        check("e_width", hi, T_EN);
        check("stable_during_e", int'(cur), int'(rise_val));
        fall_cyc = cyc;
        seen_fall = 1;
        last_hold = rise_val == 9'h001 ? T_CLR : T_CMD;
      end
      if (cur != h1 && seen_fall) check("hold_len", int'(cyc - fall_cyc > last_hold), 1);
      pe = bus.lcd_e;
      h2 = h1;
      h1 = cur;
    end
  end
  initial begin
    int n, r0, r1;
    bit busy_seen;
    bus.enable = 1'b1;
    bus.refresh_req = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_index", int'(bus.index), 0);
    check("rst_e", int'(bus.lcd_e), 0);
    check("rst_rs", int'(bus.lcd_rs), 0);
    check("rst_rw", int'(bus.lcd_rw), 0);
    check("rst_data", int'(bus.lcd_data), 0);
    check("rst_init_done", int'(bus.init_done), 0);
    check("rst_busy", int'(bus.busy), 1);
    check("rst_frame_done", int'(bus.frame_done), 0);
    push_init();
    push_frame();
    #2 rst = 1'b0;
    count_to_e(n);
    check("first_e_cycle", n, T_PWR + T_SETUP);
    n = 0;
    while (!bus.init_done && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("init_done", int'(bus.init_done), 1);
    check("clr_hold", cyc - fall_cyc, T_CLR);
    check("init_writes", e_rises, 4);
    wait_idx(5'd5, 1'b0, "reach_idx5");
    for (int i = 0; i < 3; i++) begin
      bus.refresh_req = 1'b1;
      @(negedge clk);
      bus.refresh_req = 1'b0;
      repeat (3) @(negedge clk);
    end
    push_frame();
    wait_fd("frame1_done");
    check("frame1_idx0", int'(bus.index), 0);
    check("frame1_gap_busy", int'(bus.busy), 0);
    count_to_e(n);
    check("refresh_no_gap", n, 4);
    wait_idx(5'd10, 1'b0, "reach_idx10");
    bus.enable = 1'b0;
    wait_fd("frame2_done");
    check("frame2_idx0", int'(bus.index), 0);
    r0 = e_rises;
    busy_seen = 0;
    repeat (500) begin
      @(negedge clk);
      if (bus.busy) busy_seen = 1;
    end
    check("idle_no_e", e_rises - r0, 0);
    check("idle_busy", int'(busy_seen), 0);
    check("frames", frames, 2);
    check("queue_drained", exp_q.size(), 0);
    push_frame();
    bus.enable = 1'b1;
    count_to_e(n);
    check("enable_restart", n, 4);
    wait_idx(5'd20, 1'b1, "reach_idx20_e");
    #2 rst = 1'b1;
    #1;
    check("arst_e", int'(bus.lcd_e), 0);
    check("arst_index", int'(bus.index), 0);
    check("arst_init_done", int'(bus.init_done), 0);
    check("arst_busy", int'(bus.busy), 1);
    exp_q.delete();
    push_init();
    bus.enable = 1'b0;
    @(negedge clk);
    r1 = e_rises;
    #2 rst = 1'b0;
    count_to_e(n);
    check("reinit_first_e", n, T_PWR + T_SETUP);
    n = 0;
    while (!bus.init_done && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("reinit_done", int'(bus.init_done), 1);
    repeat (60) @(negedge clk);
    check("reinit_writes", e_rises - r1, 4);
    check("reinit_queue", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
